// File: rtl/count_disp_pkg.sv
// Shared types and constants for the BCD conversion / seven-segment display block.
package count_disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int ITER_N = 10;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    function automatic logic [15:0] add3_nibbles(input logic [15:0] s);
        logic [15:0] r;
        logic [3:0]  nib;
        r = s;
        for (int i = 0; i < 4; i++) begin
            nib = s[4*i +: 4];
            if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Maps one BCD nibble to an active-low seven-segment code, with a blank override.
module bcd_to_seg
    import count_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: seg_o gets a default on every path so no latch is inferred.
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (iterative double-dabble) driving a multiplexed
// 4-digit active-low seven-segment display with leading-zero blanking.
module count_bcd_display
    import count_disp_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [9:0]  in_data,
    output logic        in_ready,
    output logic        done,
    output logic [15:0] bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t             state_q, state_d;
    logic [3:0]         iter_q;
    logic [9:0]         shift_q;
    logic [15:0]        scratch_q;
    logic [15:0]        bcd_q;
    logic               done_q;
    logic [DIV_W-1:0]   div_q;
    logic [1:0]         idx_q;

    logic               accept;
    logic               last_iter;
    logic [25:0]        conv_next;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_iter = (iter_q == 4'(ITER_N - 1));
    assign conv_next = {add3_nibbles(scratch_q), shift_q} << 1;

    // FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CONV;
            CONV:    if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = rst && (state_q == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            iter_q    <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_q   <= in_data;
                scratch_q <= '0;
                iter_q    <= '0;
            end else if (state_q == CONV) begin
                {scratch_q, shift_q} <= conv_next;
                iter_q               <= iter_q + 4'd1;
                if (last_iter) begin
                    bcd_q  <= conv_next[25:10];
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Free-running scan, independent of conversions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    logic [3:0] cur_digit;
    logic       cur_blank;
    logic       blank3, blank2, blank1;

    assign blank3 = (bcd_q[15:12] == 4'd0);
    assign blank2 = blank3 && (bcd_q[11:8] == 4'd0);
    assign blank1 = blank2 && (bcd_q[7:4] == 4'd0);

    always_comb begin
        cur_digit = bcd_q[4*idx_q +: 4];
        cur_blank = 1'b0;
        case (idx_q)
            2'd1:    cur_blank = blank1;
            2'd2:    cur_blank = blank2;
            2'd3:    cur_blank = blank3;
            default: cur_blank = 1'b0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .digit_i (cur_digit),
        .blank_i (cur_blank),
        .seg_o   (seg)
    );

    assign an   = ~(4'b0001 << idx_q);
    assign bcd  = bcd_q;
    assign done = done_q;

endmodule
